// File: rtl/sd_block_scanner.sv
// Purpose: walks consecutive SD blocks from START_BLK and issues one rd_req per block.
//          Every 512-byte sector is copied into the sram buffer while the stream is scanned for TAG.
// Latency: rd_req one cycle after start; CHECK one cycle after the 512th byte; result or next rd_req one cycle later.
// Backpressure: none. Bytes arrive on sd_valid strobes and are never stalled. READ simply waits for the next strobe.
//
// Ports:
//   clk, reset_n              clock and asynchronous active-low reset
//   start, init_finished      scan trigger (one-cycle pulse) and sd_card ready
//   rd_req, rd_addr           block read request to sd_card (registered)
//   sd_valid, sd_dout         byte stream from sd_card
//   sram_we/addr/din          sram write port (combinational, gated by READ)
//   busy, found, fail         scan status (registered)
//   found_blk, found_off      location of the first tag match
//
// Optional macro: SD_SCAN_TIMEOUT_EN adds a READ-stall watchdog. When the next byte
// would be 1,000,000 cycles late, the scan ends with fail=1.
module sd_block_scanner #(
  parameter logic [31:0] START_BLK = 32'h2000,
  parameter int unsigned MAX_BLKS  = 1024,
  parameter logic [71:0] TAG       = "DCL_START"
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        init_finished,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        sd_valid,
  input  logic [7:0]  sd_dout,
  output logic        sram_we,
  output logic [8:0]  sram_addr,
  output logic [7:0]  sram_din,
  output logic        busy,
  output logic        found,
  output logic        fail,
  output logic [31:0] found_blk,
  output logic [8:0]  found_off
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_READ,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [15:0] LAST_CNT  = 16'(MAX_BLKS - 1);
  localparam logic [9:0]  LAST_BYTE = 10'd511;

  state_t      state_q, state_d;
  logic [31:0] cur_blk_q, cur_blk_d;
  logic [15:0] blk_cnt_q, blk_cnt_d;
  logic [9:0]  byte_cnt_q, byte_cnt_d;
  logic [71:0] match_q, match_d;
  logic        hit_q, hit_d;
  logic        rd_req_q, rd_req_d;
  logic        busy_q, busy_d;
  logic        found_q, found_d;
  logic        fail_q, fail_d;
  logic [31:0] found_blk_q, found_blk_d;
  logic [8:0]  found_off_q, found_off_d;

  // The oldest byte sits in the top bits, so the register compares directly
  // against TAG. The first tag character is stored in TAG[71:64].
  logic [71:0] match_shift;
  logic        start_ok;

  assign match_shift = {match_q[63:0], sd_dout};
  assign start_ok    = start && init_finished;

`ifdef SD_SCAN_TIMEOUT_EN
  // wdog_q holds the number of cycles since the last byte, or since REQ.
  // A value of 1 is seen in the first cycle after that event. The trip fires at
  // 999,999 so that fail appears exactly 1,000,000 cycles after the last byte.
  localparam logic [19:0] WDOG_TRIP = 20'd999_999;
  logic [19:0] wdog_q, wdog_d;
`endif

  always_comb begin
    state_d     = state_q;
    cur_blk_d   = cur_blk_q;
    blk_cnt_d   = blk_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    match_d     = match_q;
    hit_d       = hit_q;
    found_d     = found_q;
    fail_d      = fail_q;
    found_blk_d = found_blk_q;
    found_off_d = found_off_q;
`ifdef SD_SCAN_TIMEOUT_EN
    wdog_d      = wdog_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // DONE holds the results. A new qualified start behaves exactly like one from IDLE.
        if (start_ok) begin
          cur_blk_d = START_BLK;
          blk_cnt_d = '0;
          found_d   = 1'b0;
          fail_d    = 1'b0;
          state_d   = S_REQ;
        end
      end

      S_REQ: begin
        // Matching restarts on every block, so a tag that spans a boundary is never detected.
        byte_cnt_d = '0;
        match_d    = '0;
        hit_d      = 1'b0;
`ifdef SD_SCAN_TIMEOUT_EN
        wdog_d     = 20'd1;
`endif
        state_d    = S_READ;
      end

      S_READ: begin
        if (sd_valid) begin
          match_d    = match_shift;
          byte_cnt_d = byte_cnt_q + 10'd1;
          // byte_cnt_q is the index of the current byte. Index 8 or higher means
          // the register holds 9 bytes of this block.
          if (!hit_q && (match_shift == TAG) && (byte_cnt_q >= 10'd8)) begin
            hit_d       = 1'b1;
            found_off_d = 9'(byte_cnt_q - 10'd8);
            found_blk_d = cur_blk_q;
          end
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = S_CHECK;
          end
`ifdef SD_SCAN_TIMEOUT_EN
          wdog_d = 20'd1;
`endif
        end
`ifdef SD_SCAN_TIMEOUT_EN
        else if (wdog_q == WDOG_TRIP) begin
          found_d = 1'b0;
          fail_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          wdog_d = wdog_q + 20'd1;
        end
`endif
      end

      S_CHECK: begin
        if (hit_q) begin
          found_d = 1'b1;
          state_d = S_DONE;
        end else if (blk_cnt_q == LAST_CNT) begin
          fail_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cur_blk_d = cur_blk_q + 32'd1;   // wraps modulo 2^32
          blk_cnt_d = blk_cnt_q + 16'd1;
          state_d   = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state. This puts rd_req and busy one cycle
    // after start, and makes found/fail rise in the same cycle that busy falls.
    rd_req_d = (state_d == S_REQ);
    busy_d   = (state_d == S_REQ) || (state_d == S_READ) || (state_d == S_CHECK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cur_blk_q   <= START_BLK;
      blk_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      match_q     <= '0;
      hit_q       <= 1'b0;
      rd_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      found_q     <= 1'b0;
      fail_q      <= 1'b0;
      found_blk_q <= '0;
      found_off_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_blk_q   <= cur_blk_d;
      blk_cnt_q   <= blk_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      match_q     <= match_d;
      hit_q       <= hit_d;
      rd_req_q    <= rd_req_d;
      busy_q      <= busy_d;
      found_q     <= found_d;
      fail_q      <= fail_d;
      found_blk_q <= found_blk_d;
      found_off_q <= found_off_d;
    end
  end

`ifdef SD_SCAN_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  // The sram write port is zero whenever no write is in progress.
  assign sram_we   = sd_valid && (state_q == S_READ);
  assign sram_addr = sram_we ? byte_cnt_q[8:0] : 9'd0;
  assign sram_din  = sram_we ? sd_dout : 8'd0;

  assign rd_req    = rd_req_q;
  assign rd_addr   = cur_blk_q;
  assign busy      = busy_q;
  assign found     = found_q;
  assign fail      = fail_q;
  assign found_blk = found_blk_q;
  assign found_off = found_off_q;

endmodule

// File: tb/tb_sd_block_scanner.sv
module tb_sd_block_scanner;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        init_finished;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        sd_valid;
  logic [7:0]  sd_dout;
  logic        sram_we;
  logic [8:0]  sram_addr;
  logic [7:0]  sram_din;
  logic        busy;
  logic        found;
  logic        fail;
  logic [31:0] found_blk;
  logic [8:0]  found_off;

  sd_block_scanner #(
    .START_BLK(32'h2000),
    .MAX_BLKS (4),
    .TAG      ("DCL_START")
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .init_finished(init_finished),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .sd_valid     (sd_valid),
    .sd_dout      (sd_dout),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_din     (sram_din),
    .busy         (busy),
    .found        (found),
    .fail         (fail),
    .found_blk    (found_blk),
    .found_off    (found_off)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fnd;
    logic        fl;
    logic        chk_loc;
    logic [31:0] blk;
    logic [8:0]  off;
  } res_t;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_req_q[$];
  logic [16:0] exp_wr_q[$];
  res_t        exp_res_q[$];
  logic [7:0]  bmem[4][512];
  logic [71:0] tag_v = "DCL_START";
  logic        prev_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expectations pushed by the stimulus whenever the DUT presents an event.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_busy = 1'b0;
    end else begin
      if (rd_req) begin
        check("rd_req expected", 64'(exp_req_q.size() > 0), 64'd1);
        if (exp_req_q.size() > 0) check("rd_addr", 64'(rd_addr), 64'(exp_req_q.pop_front()));
      end
      if (sram_we) begin
        check("sram write expected", 64'(exp_wr_q.size() > 0), 64'd1);
        if (exp_wr_q.size() > 0) check("sram addr/din", 64'({sram_addr, sram_din}), 64'(exp_wr_q.pop_front()));
      end
      if (prev_busy && !busy) begin
        check("result expected", 64'(exp_res_q.size() > 0), 64'd1);
        if (exp_res_q.size() > 0) begin
          res_t r;
          r = exp_res_q.pop_front();
          check("found", 64'(found), 64'(r.fnd));
          check("fail", 64'(fail), 64'(r.fl));
          if (r.chk_loc) begin
            check("found_blk", 64'(found_blk), 64'(r.blk));
            check("found_off", 64'(found_off), 64'(r.off));
          end
        end
      end
      prev_busy = busy;
    end
  end

  task automatic fill_filler();
    // Bytes with the top bit set can never form part of the ASCII tag.
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 512; i++)
        bmem[b][i] = 8'h80 | 8'((b * 37 + i) & 8'h7f);
  endtask

  task automatic put_tag(input int b, input int off);
    for (int k = 0; k < 9; k++) begin
      if (off + k < 512) bmem[b][off + k] = tag_v[71 - 8 * k -: 8];
      else               bmem[b + 1][off + k - 512] = tag_v[71 - 8 * k -: 8];
    end
  endtask

  function automatic res_t mk_res(input logic f, input logic fl, input logic c,
                                  input logic [31:0] blk, input logic [8:0] off);
    res_t r;
    r.fnd = f; r.fl = fl; r.chk_loc = c; r.blk = blk; r.off = off;
    return r;
  endfunction

  // Called at posedge+1. Pulses start, then checks rd_req and busy one cycle later.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rd_req after start", 64'(rd_req), 64'd1);
    check("busy after start", 64'(busy), 64'd1);
  endtask

  task automatic wait_rdreq();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rd_req) break;
    end
    check("rd_req arrival", 64'(rd_req), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("scan completes", 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  // Streams n bytes of block b, starting at posedge+1 of the first READ cycle.
  // gap_at inserts 3 idle cycles. start_at pulses start while busy. stray drives one
  // sd_valid strobe into the CHECK cycle, which the DUT must not write.
  task automatic stream_block(input int b, input int n, input int gap_at,
                              input int start_at, input bit stray);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        sd_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
      end
      start    = (i == start_at);
      sd_valid = 1'b1;
      sd_dout  = bmem[b][i];
      exp_wr_q.push_back({9'(i), bmem[b][i]});
      @(posedge clk); #1;
    end
    start    = 1'b0;
    sd_valid = 1'b0;
    sd_dout  = 8'hFF;
    if (stray) begin
      sd_valid = 1'b1;
      sd_dout  = 8'h44;
      @(posedge clk); #1;
      sd_valid = 1'b0;
      sd_dout  = 8'hFF;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; init_finished = 1'b0;
    sd_valid = 1'b0; sd_dout = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    // Reset values
    check("reset rd_req", 64'(rd_req), 64'd0);
    check("reset rd_addr", 64'(rd_addr), 64'h2000);
    check("reset busy", 64'(busy), 64'd0);
    check("reset found", 64'(found), 64'd0);
    check("reset fail", 64'(fail), 64'd0);
    check("reset found_blk", 64'(found_blk), 64'd0);
    check("reset found_off", 64'(found_off), 64'd0);
    check("reset sram port", 64'({sram_we, sram_addr, sram_din}), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // A start without init_finished is ignored. The monitor flags any stray rd_req.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("no init: busy", 64'(busy), 64'd0);

    // Scenario 1: tag at 0x010, with a second copy at 0x100 that must be ignored.
    init_finished = 1'b1;
    fill_filler();
    put_tag(0, 16);
    put_tag(0, 256);
    exp_req_q.push_back(32'h2000);
    exp_res_q.push_back(mk_res(1'b1, 1'b0, 1'b1, 32'h2000, 9'h010));
    do_start();
    wait_rdreq();
    stream_block(0, 512, -1, 50, 1'b0);
    wait_idle();
    // sd_valid while in DONE must not write the sram.
    sd_valid = 1'b1; sd_dout = 8'h44;
    repeat (3) begin @(posedge clk); #1; end
    sd_valid = 1'b0; sd_dout = 8'hFF;

    // Scenario 2: tag only at bytes 503..511 of block 0x2003. This run restarts from DONE.
    fill_filler();
    put_tag(3, 503);
    for (int b = 0; b < 4; b++) exp_req_q.push_back(32'h2000 + 32'(b));
    exp_res_q.push_back(mk_res(1'b1, 1'b0, 1'b1, 32'h2003, 9'h1F7));
    do_start();
    for (int b = 0; b < 4; b++) begin
      wait_rdreq();
      stream_block(b, 512, (b == 1) ? 100 : -1, -1, b < 3);
    end
    wait_idle();

    // Scenario 3: tag split across blocks 0x2001/0x2002. The scan must end in fail.
    fill_filler();
    put_tag(1, 508);
    for (int b = 0; b < 4; b++) exp_req_q.push_back(32'h2000 + 32'(b));
    exp_res_q.push_back(mk_res(1'b0, 1'b1, 1'b0, 32'h0, 9'h0));
    do_start();
    for (int b = 0; b < 4; b++) begin
      wait_rdreq();
      stream_block(b, 512, -1, -1, 1'b0);
    end
    wait_idle();
    check("fail final rd_addr", 64'(rd_addr), 64'h2003);
    check("fail found flag", 64'(found), 64'd0);
    check("fail flag held", 64'(fail), 64'd1);

    // Scenario 4: reset asserted at byte 200 of the first block, then a full rescan.
    fill_filler();
    put_tag(0, 0);
    exp_req_q.push_back(32'h2000);
    do_start();
    wait_rdreq();
    stream_block(0, 200, -1, -1, 1'b0);
    reset_n = 1'b0;
    #1;
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset rd_req", 64'(rd_req), 64'd0);
    check("async reset rd_addr", 64'(rd_addr), 64'h2000);
    check("async reset fail", 64'(fail), 64'd0);
    check("async reset found_blk", 64'(found_blk), 64'd0);
    check("async reset found_off", 64'(found_off), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    exp_req_q.push_back(32'h2000);
    exp_res_q.push_back(mk_res(1'b1, 1'b0, 1'b1, 32'h2000, 9'h000));
    do_start();
    wait_rdreq();
    stream_block(0, 512, -1, -1, 1'b0);
    wait_idle();

    // Scenario 5: the byte stream stops after 100 bytes. The scan stays busy.
    exp_req_q.push_back(32'h2000);
    do_start();
    wait_rdreq();
    stream_block(0, 100, -1, -1, 1'b0);
    repeat (300) @(posedge clk);
    #1;
    check("stalled scan busy", 64'(busy), 64'd1);
    check("stalled scan fail", 64'(fail), 64'd0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    check("rd_req queue drained", 64'(exp_req_q.size()), 64'd0);
    check("write queue drained", 64'(exp_wr_q.size()), 64'd0);
    check("result queue drained", 64'(exp_res_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
